// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared types, register offsets and load formatting for the       |
// |           memory-mapped UART transmitter.                                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

    // RV32I load width/sign handling applied to a full register word.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'd0, w[15:0]};
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo                                                        |
// | Brief   : Single-clock FIFO; a push into a full FIFO succeeds when a pop   |
// |           happens in the same cycle.                                       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign dout    = r_mem[r_rd_ptr];
    assign w_pop   = pop & ~empty;
    assign w_push  = push & (~full | w_pop);
    assign push_ok = w_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_uart_tx                                                     |
// | Brief   : Data-bus mapped 8N1 UART transmitter with TX FIFO, status and    |
// |           programmable baud divisor.                                       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLK_FREQ   = 12_000_000,
    parameter int          BAUD       = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        tx,
    output logic        tx_busy
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] RESET_DIV = 16'(CLK_FREQ / BAUD);

    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [7:0]    w_fifo_dout;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    logic          r_ovf;
    logic [15:0]   r_div;

    uart_state_t   r_state, w_state_nxt;
    logic [15:0]   r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic          w_bit_end;

    assign w_hit      = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign w_off      = dmem_address[3:2];
    assign w_wr       = dmem_wren & w_hit;
    assign w_push_req = w_wr & (w_off == OFF_TXDATA);
    assign w_unused   = ^{dmem_address[1:0], dmem_data_in[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push_req),
        .din     (dmem_data_in[7:0]),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count),
        .push_ok (w_push_ok)
    );

    // Overflow set wins over a same-cycle software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_div <= RESET_DIV;
        end else begin
            if (w_push_req && !w_push_ok)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == OFF_STATUS) && dmem_data_in[ST_OVF])
                r_ovf <= 1'b0;
            if (w_wr && (w_off == OFF_BAUD))
                r_div <= (dmem_data_in[15:0] == 16'd0) ? 16'd1 : dmem_data_in[15:0];
        end
    end

    always_comb begin
        w_rd_word = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS: begin
                    w_rd_word[ST_BUSY]            = tx_busy;
                    w_rd_word[ST_FULL]            = w_fifo_full;
                    w_rd_word[ST_EMPTY]           = w_fifo_empty;
                    w_rd_word[ST_OVF]             = r_ovf;
                    w_rd_word[ST_CNT_LO+3:ST_CNT_LO] = 4'(w_fifo_count);
                end
                OFF_BAUD: w_rd_word[15:0] = r_div;
                default:  w_rd_word = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dmem_data_out <= 32'd0;
        else       dmem_data_out <= fmt_load(funct3, w_rd_word);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_shift <= 8'd0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign w_bit_end = (r_cnt == 16'd1);

    // Every bit reloads the divisor, so a new BAUD_DIV applies at the next boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_cnt_nxt   = r_div;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = r_div;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = r_div;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) w_state_nxt = STOP;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_cnt_nxt   = r_div;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        if (r_state == START)     tx = 1'b0;
        else if (r_state == DATA) tx = r_shift[0];
    end

    assign tx_busy = (r_state != IDLE) | (w_fifo_count != '0);

endmodule
`default_nettype wire
